// File: rtl/calc_btn_pkg.sv
// Shared calculator keypad definitions: key count, code width helper and named key indices.
package calc_btn_pkg;

    localparam int NUM_BTN = 16;

    typedef logic [3:0] btn_code_t;

    localparam btn_code_t KEY_0   = 4'd0;
    localparam btn_code_t KEY_1   = 4'd1;
    localparam btn_code_t KEY_2   = 4'd2;
    localparam btn_code_t KEY_3   = 4'd3;
    localparam btn_code_t KEY_4   = 4'd4;
    localparam btn_code_t KEY_5   = 4'd5;
    localparam btn_code_t KEY_6   = 4'd6;
    localparam btn_code_t KEY_7   = 4'd7;
    localparam btn_code_t KEY_8   = 4'd8;
    localparam btn_code_t KEY_9   = 4'd9;
    localparam btn_code_t KEY_ADD = 4'd10;
    localparam btn_code_t KEY_SUB = 4'd11;
    localparam btn_code_t KEY_MUL = 4'd12;
    localparam btn_code_t KEY_DIV = 4'd13;
    localparam btn_code_t KEY_EQ  = 4'd14;
    localparam btn_code_t KEY_CLR = 4'd15;

    function automatic int code_w(input int width);
        return $clog2(width);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_fifo.sv
// Synchronous FIFO, head visible combinationally from registered storage; push lands after the edge.
// Push into a full FIFO is accepted only when a pop happens in the same cycle; pop on empty is ignored.
module btn_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/btn_event_queue.sv
// Button levels -> key-press event stream; a rise sampled at an edge is at the FIFO head after that edge.
// Presses wait in a pending mask while the FIFO is full; BTN_REPEAT_EN adds auto-repeat of the lowest held key.
module btn_event_queue
    import calc_btn_pkg::*;
#(
    parameter int  WIDTH        = NUM_BTN,
    parameter int  DEPTH        = 4,
    parameter int  REPEAT_DELAY = 50_000_000,
    parameter int  REPEAT_RATE  = 10_000_000,
    localparam int CODE_W       = code_w(WIDTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_btn,
    output logic              o_valid,
    output logic [CODE_W-1:0] o_code,
    input  logic              i_ready,
    output logic              o_drop,
    output logic              o_any
);

    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  cand;
    logic [WIDTH-1:0]  sel_mask;
    logic [WIDTH-1:0]  inject;
    logic [CODE_W-1:0] sel_idx;
    logic              drop_q, drop_d;
    logic              any_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;

    always_comb begin
        rise     = i_btn & ~prev_q;
        cand     = pending_q | rise;
        sel_mask = cand & (~cand + WIDTH'(1));
        sel_idx  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_idx = CODE_W'(i);
            end
        end
        pop       = ~fifo_empty & i_ready;
        push      = (|cand) & (~fifo_full | pop);
        pending_d = push ? (cand & ~sel_mask) : cand;
        // Repeat injections merge into pending silently; only real rises count as drops.
        pending_d = pending_d | inject;
        drop_d    = |(rise & pending_q);
    end

`ifdef BTN_REPEAT_EN
    localparam int CNT_W = code_w(max_int(max_int(REPEAT_DELAY, REPEAT_RATE), 2));
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] held_low;

    always_comb begin
        held_low = i_btn & (~i_btn + WIDTH'(1));
        cnt_d    = cnt_q;
        inject   = '0;
        if (i_btn != prev_q) begin
            cnt_d = DELAY_LD;
        end else if (|i_btn) begin
            if (cnt_q == '0) begin
                inject = held_low;
                cnt_d  = RATE_LD;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign inject = '0;

    // Repeat timing has no meaning without auto-repeat; referenced only so it is not left dangling.
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_unused
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
            any_q     <= 1'b0;
        end else begin
            prev_q    <= i_btn;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            any_q     <= |i_btn;
        end
    end

    btn_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .push_i  (push),
        .data_i  (sel_idx),
        .pop_i   (pop),
        .data_o  (o_code),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign o_valid = ~fifo_empty;
    assign o_drop  = drop_q;
    assign o_any   = any_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Randomized and directed stimulus against a queue-based reference model of the key event stream.
module tb_btn_event_queue;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RR = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] btn;
    logic        ready;
    logic        valid;
    logic [3:0]  code;
    logic        drop;
    logic        any;

    always #5 clk = ~clk;

    btn_event_queue #(
        .WIDTH        (W),
        .DEPTH        (D),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn),
        .o_valid (valid),
        .o_code  (code),
        .i_ready (ready),
        .o_drop  (drop),
        .o_any   (any)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: event list, outstanding-press mask, last-seen buttons.
    int          m_q[$];
    logic [15:0] m_prev;
    logic [15:0] m_pend;
    logic        m_drop;
    logic        m_any;
    int          m_cnt;
    int          got[$];

    task automatic model_reset();
        m_q.delete();
        m_prev = '0;
        m_pend = '0;
        m_drop = 1'b0;
        m_any  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic [15:0] b, input logic rdy);
        logic [15:0] rise;
        logic [15:0] c;
        bit          popped;
        bit          room;
        rise   = b & ~m_prev;
        c      = m_pend | rise;
        popped = (m_q.size() != 0) && rdy;
        room   = (m_q.size() < D) || popped;
        m_drop = |(rise & m_pend);
        if (popped) void'(m_q.pop_front());
        if (room && c != 0) begin
            for (int i = 0; i < W; i++) begin
                if (c[i]) begin
                    m_q.push_back(i);
                    c[i] = 1'b0;
                    break;
                end
            end
        end
`ifdef BTN_REPEAT_EN
        if (b != m_prev) begin
            m_cnt = RD - 1;
        end else if (b != 0) begin
            if (m_cnt == 0) begin
                for (int i = 0; i < W; i++) begin
                    if (b[i]) begin
                        c[i] = 1'b1;
                        break;
                    end
                end
                m_cnt = RR - 1;
            end else begin
                m_cnt--;
            end
        end
`endif
        m_pend = c;
        m_prev = b;
        m_any  = |b;
    endtask

    task automatic compare();
        chk("valid", {31'b0, valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) chk("code", {28'b0, code}, m_q[0]);
        chk("drop", {31'b0, drop}, {31'b0, m_drop});
        chk("any", {31'b0, any}, {31'b0, m_any});
    endtask

    // Called at a negedge: drive inputs, advance model, wait one edge, compare.
    task automatic cycle(input logic [15:0] b, input logic rdy);
        btn   = b;
        ready = rdy;
        model_step(b, rdy);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    // Hold b with ready high for n cycles, recording each code that is handed over.
    task automatic drain(input logic [15:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            if (valid) got.push_back(int'(code));
            cycle(b, 1'b1);
        end
    endtask

    initial begin
        int drops;
        logic [15:0] rb;
        rst_n = 1'b0;
        btn   = '0;
        ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_code", {28'b0, code}, 0);
        chk("rst_drop", {31'b0, drop}, 0);
        chk("rst_any", {31'b0, any}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single press on key 2.
        for (int k = 0; k < 9; k++) cycle(16'h0000, 1'b1);
        cycle(16'h0004, 1'b1);
        chk("single_valid", {31'b0, valid}, 1);
        chk("single_code", {28'b0, code}, 2);
        cycle(16'h0004, 1'b1);
        chk("single_once", {31'b0, valid}, 0);
        got.delete();
        drain(16'h0004, 5);
        drain(16'h0000, 3);
        chk("single_no_more", got.size(), 0);

        // Simultaneous presses serialise lowest index first.
        got.delete();
        drain(16'h8421, 7);
        chk("simul_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("simul_0", got[0], 0);
            chk("simul_1", got[1], 5);
            chk("simul_2", got[2], 10);
            chk("simul_3", got[3], 15);
        end
        drain(16'h0000, 2);

        // Backpressure: keys 1..6 with consumer stalled, then a merged re-press of key 7.
        for (int k = 1; k <= 6; k++) cycle(16'(1 << k), 1'b0);
        chk("full_valid", {31'b0, valid}, 1);
        chk("full_head", {28'b0, code}, 1);
        drops = 0;
        cycle(16'h0080, 1'b0); drops += int'(drop);
        cycle(16'h0000, 1'b0); drops += int'(drop);
        cycle(16'h0080, 1'b0); drops += int'(drop);
        cycle(16'h0000, 1'b0); drops += int'(drop);
        cycle(16'h0000, 1'b0); drops += int'(drop);
        chk("merge_drops", drops, 1);
        got.delete();
        drain(16'h0000, 12);
        chk("bp_count", got.size(), 7);
        for (int k = 0; k < got.size() && k < 7; k++) chk("bp_order", got[k], k + 1);

        // Asynchronous reset while an event is waiting and key 3 is held.
        cycle(16'h0008, 1'b0);
        chk("pre_rst_code", {28'b0, code}, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", {31'b0, valid}, 0);
        chk("mid_rst_code", {28'b0, code}, 0);
        chk("mid_rst_drop", {31'b0, drop}, 0);
        chk("mid_rst_any", {31'b0, any}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        drain(16'h0008, 6);
        chk("post_rst_count", got.size(), 1);
        if (got.size() == 1) chk("post_rst_code", got[0], 3);
        drain(16'h0000, 2);

`ifdef BTN_REPEAT_EN
        drain(16'h0200, 30);
        drain(16'h0204, 20);
        drain(16'h0000, 6);
`endif

        // Randomized level changes with random consumer stalls.
        rb = '0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) rb[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) rb = 16'($urandom);
            cycle(rb, $urandom_range(0, 3) != 0);
        end
        drain(16'h0000, 24);
        chk("final_empty", {31'b0, valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_event_queue.md
# btn_event_queue

Converts the debounced, level-valued button vector into a stream of discrete key-press events for the calculator core. Sits directly downstream of the debouncer. Detects rising edges, holds simultaneous presses in a pending mask, and serialises them lowest-index-first into a small FIFO. The FIFO drains through a valid/ready handshake. Optional auto-repeat generates further events for a held key.

## Interface
Parameters:
- WIDTH, 16, number of buttons; WIDTH >= 2.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- REPEAT_DELAY, 50_000_000, cycles a key is held before its first repeat (BTN_REPEAT_EN only).
- REPEAT_RATE, 10_000_000, cycles between subsequent repeats (BTN_REPEAT_EN only).

Ports:
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_btn  in  WIDTH  debounced button levels; 1 = pressed.
- o_valid  out  1  FIFO non-empty; o_code is meaningful.
- o_code  out  CODE_W  key index, where CODE_W = $clog2(WIDTH); FIFO head.
- i_ready  in  1  consumer accepts the head when o_valid & i_ready.
- o_drop  out  1  one-cycle pulse when a press is merged or lost.
- o_any  out  1  registered OR of i_btn.

## Operation
- prev register holds last cycle's i_btn; rise = i_btn & ~prev.
- cand = pending | rise. Each cycle, if push is allowed, the lowest set bit of cand is pushed as its index. That bit is cleared; all other cand bits are written to pending.
- If push is not allowed, pending <= cand.
- Push is allowed when the FIFO is not full, or when it is full and a pop occurs the same cycle.
- Pop: o_valid & i_ready; the head advances.
- Merge: a rise on bit b while pending[b] is already set keeps one event and pulses o_drop.
- A release before service does not cancel a pending press.
- FIFO: DEPTH entries; read/write pointers are log2(DEPTH)+1 bits wide. Full means the MSBs differ and the rest are equal; empty means the pointers are equal. Pointers wrap naturally.
- Reset (any time, including mid-operation): prev=0, pending=0, FIFO empty, o_valid=0, o_code=0, o_drop=0, o_any=0, repeat counter=0. A button held through reset release produces exactly one event.

## Timing
- Latency: a rise sampled at edge k with an empty FIFO gives o_valid=1 and the matching o_code after edge k.
- Throughput: one push and one pop per cycle, sustained.
- o_code and o_valid change only on clock edges. o_code holds while o_valid & ~i_ready.
- o_drop is registered and asserts the cycle after the merge.

## Configuration
- BTN_REPEAT_EN defined: the repeat target is the lowest-index held bit of i_btn.
  - The down-counter loads REPEAT_DELAY-1 on any change of i_btn; otherwise it decrements while any key is held.
  - At zero it sets pending[target] and reloads REPEAT_RATE-1.
  - An injected repeat on an already-pending bit merges silently, with no o_drop.
  - The counter is $clog2(max(REPEAT_DELAY, REPEAT_RATE)) bits wide.
- BTN_REPEAT_EN undefined: no counter and no repeat logic; each press gives exactly one event. REPEAT_* parameters are ignored.

## Structure
- Shared package calc_btn_pkg:
  - NUM_BTN default (16).
  - Function code_w(width).
  - typedef btn_code_t as logic [3:0] for the calculator's 16-key set.
  - Named key-index constants (KEY_0..KEY_9, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_EQ, KEY_CLR).
- One sub-module, btn_fifo: synchronous FIFO with parameters WIDTH and DEPTH and a push/pop/full/empty interface, the same clock, and the same async active-low reset. Edge detection, pending mask, priority select and repeat stay in the top module.

## Test plan
Bench parameters: WIDTH=16, DEPTH=4, REPEAT_DELAY=8, REPEAT_RATE=4.
- Single press: i_btn=0x0004 from edge 10, i_ready=1 -> o_valid=1 with o_code=2 for exactly one cycle after edge 10. No further events while held or on release.
- Simultaneous presses: i_btn=0x8421 in one cycle, i_ready=1 -> codes 0, 5, 10, 15 on four consecutive cycles; o_drop stays 0.
- Backpressure/full: i_ready=0, presses on keys 1..6 in consecutive cycles. Result: FIFO holds 1, 2, 3, 4 and pending holds 5 and 6. After i_ready=1: 1, 2, 3, 4, 5, 6 in order, with no loss.
- Merge: i_ready=0 with the FIFO full, key 7 pressed, released and pressed again -> o_drop pulses once. After drain, exactly one code 7.
- Reset mid-operation: deassert i_rst_n while o_valid=1 and key 3 is held -> all outputs 0 immediately. After release of reset, one code 3 event.
- Repeat (BTN_REPEAT_EN): hold key 9 -> events at about press+1, +8, +12, +16 cycles. Pressing key 2 during the hold restarts the delay and moves the repeat target to key 2.
